// File: rtl/mdu_pkg.sv
// Op codes, state encoding and decode helpers shared by the MDU, the decoder and the stall unit.
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ITER  = 2'd1;
  localparam logic [1:0] ST_FIXUP = 2'd2;

  function automatic logic is_long_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
                      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction

endpackage

// File: rtl/iter_mdu_if.sv
// Issue/result bundle between the EX stage and the MDU.
interface iter_mdu_if #(parameter int WIDTH = 32);
  logic             flush;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       MDUop;
  logic             start;
  logic             busy;
  logic [WIDTH-1:0] MDUresult;

  modport master (output flush, A, B, MDUop, input start, busy, MDUresult);
  modport slave  (input flush, A, B, MDUop, output start, busy, MDUresult);
endinterface

// File: rtl/mdu_iter_core.sv
// Unsigned magnitude datapath: shift-add multiply and restoring divide, one bit per step.
module mdu_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_mag_i,
  input  logic [WIDTH-1:0]   b_mag_i,
  input  logic               step_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] res_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   bq_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               div_q;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;

  // mul: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}
  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, bq_q};
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, bq_q};
    acc_d   = acc_q;
    if (div_q) begin
      if (diff[WIDTH]) acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else             acc_d = {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
    end else begin
      if (acc_q[0]) acc_d = {add_sum, acc_q[WIDTH-1:1]};
      else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      bq_q  <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      acc_q <= {{WIDTH{1'b0}}, a_mag_i};
      bq_q  <= b_mag_i;
      div_q <= is_div_i;
      cnt_q <= CNT_W'(WIDTH);
    end else if (step_i && cnt_q != '0) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_o = (cnt_q == '0);
  assign res_o  = acc_q;

endmodule

// File: rtl/iter_mdu.sv
// Iterative MDU: owns HI/LO, operand sign handling, result fix-up, flush and the issue handshake.
module iter_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic  clk,
  input  logic  reset,
  iter_mdu_if.slave bus
);

  logic               busy_q, busy_d;
  logic [3:0]         op_q;
  logic               sa_q, sb_q, bz_q;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [1:0]         state;

  logic               start;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               done;
  logic [2*WIDTH-1:0] res, prod, mac;
  logic [WIDTH-1:0]   quo_f, rem_f;

  assign start = is_long_op(bus.MDUop) & ~busy_q & ~bus.flush;
  assign a_neg = is_signed_op(bus.MDUop) & bus.A[WIDTH-1];
  assign b_neg = is_signed_op(bus.MDUop) & bus.B[WIDTH-1];
  assign a_mag = a_neg ? -bus.A : bus.A;
  assign b_mag = b_neg ? -bus.B : bus.B;

  always_comb begin
    state = ST_IDLE;
    if (busy_q) state = done ? ST_FIXUP : ST_ITER;
  end

  mdu_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (bus.flush),
    .load_i   (start),
    .is_div_i (is_div_op(bus.MDUop)),
    .a_mag_i  (a_mag),
    .b_mag_i  (b_mag),
    .step_i   ((state == ST_ITER) & ~bus.flush),
    .done_o   (done),
    .res_o    (res)
  );

  // Zero divisor keeps the all-ones quotient unsigned so LO is all-ones whatever the dividend sign.
  assign prod  = (sa_q ^ sb_q) ? -res : res;
  assign quo_f = (sa_q ^ sb_q) & ~bz_q ? -res[WIDTH-1:0] : res[WIDTH-1:0];
  assign rem_f = sa_q ? -res[2*WIDTH-1:WIDTH] : res[2*WIDTH-1:WIDTH];

  always_comb begin
    mac = prod;
    case (op_q)
      MDU_MADD, MDU_MADDU: mac = {hi_q, lo_q} + prod;
      MDU_MSUB, MDU_MSUBU: mac = {hi_q, lo_q} - prod;
      default:             mac = prod;
    endcase
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
    end else if (state == ST_FIXUP) begin
      busy_d = 1'b0;
      if (is_div_op(op_q)) {hi_d, lo_d} = {rem_f, quo_f};
      else                 {hi_d, lo_d} = mac;
    end else if (!busy_q) begin
      if (bus.MDUop == MDU_MTHI) hi_d = bus.A;
      if (bus.MDUop == MDU_MTLO) lo_d = bus.A;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      op_q   <= MDU_NOP;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      bz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      if (start) begin
        op_q <= bus.MDUop;
        sa_q <= a_neg;
        sb_q <= b_neg;
        bz_q <= (bus.B == '0);
      end
    end
  end

  always_comb begin
    bus.MDUresult = '0;
    if (bus.MDUop == MDU_MFHI) bus.MDUresult = hi_q;
    if (bus.MDUop == MDU_MFLO) bus.MDUresult = lo_q;
  end

  assign bus.start = start;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_iter_mdu.sv
// Directed vectors for iter_mdu at WIDTH=32 with hand-computed HI/LO results.
module tb_iter_mdu;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  iter_mdu_if #(.WIDTH(32)) bus ();

  iter_mdu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    bus.MDUop = MDU_MFHI;
    #1 check({tag, ".hi"}, 64'(bus.MDUresult), 64'(eh));
    bus.MDUop = MDU_MFLO;
    #1 check({tag, ".lo"}, 64'(bus.MDUresult), 64'(el));
    bus.MDUop = MDU_NOP;
    #1;
  endtask

  task automatic accept(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.MDUop = op; bus.A = a; bus.B = b;
    #1 check({tag, ".start"}, 64'(bus.start), 64'd1);
    @(posedge clk);
    #1 bus.MDUop = MDU_NOP;
    check({tag, ".busy"}, 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(exp_cycles));
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    accept(tag, op, a, b);
    wait_done(tag, 33);
    read_hilo(tag, eh, el);
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    bus.MDUop = op; bus.A = a;
    @(posedge clk);
    #1 bus.MDUop = MDU_NOP;
  endtask

  initial begin
    errors = 0; checks = 0;
    bus.flush = 1'b0; bus.A = '0; bus.B = '0; bus.MDUop = MDU_NOP;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.start", 64'(bus.start), 64'd0);
    read_hilo("rst", 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    run_op("mult", MDU_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    check("nop.result", 64'(bus.MDUresult), 64'd0);
    run_op("divu", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("div0", MDU_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("divu0", MDU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    run_op("div0_neg", MDU_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);

    move_to(MDU_MTHI, 32'd1);
    move_to(MDU_MTLO, 32'd2);
    read_hilo("mt", 32'd1, 32'd2);
    // 1_00000002 + (FFFFFFFF*2 = 1_FFFFFFFE) = 3_00000000
    run_op("maddu", MDU_MADDU, 32'hFFFFFFFF, 32'd2, 32'h3, 32'h0);
    run_op("msub", MDU_MSUB, 32'd1, 32'd1, 32'h2, 32'hFFFFFFFF);

    // mult offered while busy must be ignored
    accept("busy_mult", MDU_MULTU, 32'd3, 32'd4);
    bus.MDUop = MDU_MULT; bus.A = 32'hFFFFFFFF; bus.B = 32'hFFFFFFFF;
    #1 check("busy_mult.start", 64'(bus.start), 64'd0);
    @(posedge clk);
    #1 bus.MDUop = MDU_NOP;
    wait_done("busy_mult", 32);
    read_hilo("busy_mult", 32'h0, 32'd12);

    // 0_0000000C + (-1) = 0_0000000B
    run_op("madd", MDU_MADD, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0000000B);
    // 0_0000000B - FFFFFFFE_00000001 = 2_0000000A
    run_op("msubu", MDU_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h0000000A);

    accept("flush10", MDU_MULTU, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1 check("flush10.pre", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("flush10.busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1 check("flush10.idle", 64'(bus.busy), 64'd0);
    read_hilo("flush10", 32'h2, 32'h0000000A);

    accept("flush33", MDU_MULTU, 32'd5, 32'd6);
    repeat (32) @(posedge clk);
    #1 check("flush33.pre", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    check("flush33.busy", 64'(bus.busy), 64'd0);
    read_hilo("flush33", 32'h2, 32'h0000000A);

    @(negedge clk);
    bus.MDUop = MDU_MULT; bus.A = 32'd9; bus.B = 32'd9; bus.flush = 1'b1;
    #1 check("flush_long.start", 64'(bus.start), 64'd0);
    @(posedge clk);
    #1 check("flush_long.busy", 64'(bus.busy), 64'd0);
    bus.MDUop = MDU_MTHI; bus.A = 32'hDEAD;
    @(posedge clk);
    #1 bus.flush = 1'b0; bus.MDUop = MDU_NOP;
    read_hilo("flush_mt", 32'h2, 32'h0000000A);

    @(negedge clk);
    bus.MDUop = 4'd13;
    #1 check("op13.start", 64'(bus.start), 64'd0);
    check("op13.result", 64'(bus.MDUresult), 64'd0);
    @(posedge clk);
    #1 check("op13.busy", 64'(bus.busy), 64'd0);
    bus.MDUop = MDU_NOP;

    accept("rst_mid", MDU_DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1 check("rst_mid.busy", 64'(bus.busy), 64'd0);
    read_hilo("rst_mid", 32'h0, 32'h0);
    @(negedge clk) reset = 1'b1;
    run_op("post_rst", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
